elastic_fifo: RTL and testbench

- Parametrised elastic buffer with valid/ready handshake on both sides and first-word-fall-through output.
- Sits between pipeline stages of the decoder and flit paths to decouple producer from consumer.
- Adds to the previous buffer generation:
  - arbitrary width and depth;
  - occupancy count and almost-full/almost-empty flags;
  - synchronous flush;
  - well-defined simultaneous push/pop.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_ptr.sv | 30 +++
 rtl/elastic_fifo.sv | 82 ++++++++
 tb/tb_elastic_fifo.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the elastic FIFO and its pointer sub-module.
package fifo_pkg;

   localparam int DEFAULT_WIDTH = 10;
   localparam int DEFAULT_DEPTH = 16;

   // Number of bits needed to index 'value' distinct states (0 for value <= 1).
   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result++;
      end
      return result;
   endfunction

   function automatic int unsigned wrap_inc(input int unsigned ptr, input int unsigned depth);
      return (ptr == depth - 1) ? 32'd0 : ptr + 32'd1;
   endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Circular slot pointer that wraps at DEPTH-1, with synchronous clear taking priority over increment.
module fifo_ptr
   import fifo_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int PW    = clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          clr,
   input  logic          inc,
   output logic [PW-1:0] ptr
);

   logic [PW-1:0] r_ptr;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (clr) begin
         r_ptr <= '0;
      end else if (inc) begin
         r_ptr <= PW'(wrap_inc(32'(r_ptr), DEPTH));
      end
   end

   assign ptr = r_ptr;

endmodule

// File: rtl/elastic_fifo.sv
// First-word-fall-through elastic buffer with valid/ready on both sides, occupancy count and watermark flags.
module elastic_fifo
   import fifo_pkg::*;
#(
   parameter  int WIDTH    = DEFAULT_WIDTH,
   parameter  int DEPTH    = DEFAULT_DEPTH,
   parameter  int AF_LEVEL = DEPTH - 2,
   parameter  int AE_LEVEL = 1,
   localparam int CW       = clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CW-1:0]    count,
   output logic             almost_full,
   output logic             almost_empty
);

   localparam int PW = clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [CW-1:0]    r_count;
   logic [PW-1:0]    w_wr_ptr;
   logic [PW-1:0]    w_rd_ptr;
   logic             w_push;
   logic             w_pop;

   // in_ready looks only at the count register and flush, never at out_ready.
   assign in_ready  = (r_count != CW'(DEPTH)) & ~flush;
   assign out_valid = (r_count != '0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (w_push),
      .ptr   (w_wr_ptr)
   );

   fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk   (clk),
      .reset (reset),
      .clr   (flush),
      .inc   (w_pop),
      .ptr   (w_rd_ptr)
   );

   // NOTE: the storage array has no reset; validity is tracked by the count, so a reset here would only cost flops.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[w_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_data     = out_valid ? r_mem[w_rd_ptr] : '0;
   assign count        = r_count;
   assign almost_full  = (r_count >= CW'(AF_LEVEL));
   assign almost_empty = (r_count <= CW'(AE_LEVEL));

endmodule

// File: tb/tb_elastic_fifo.sv
// Directed bench for elastic_fifo at DEPTH=16 and DEPTH=5, with a small queue model for the random phase.
module tb_elastic_fifo;

   logic clk;
   logic reset;

   logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic       a_almost_full, a_almost_empty;
   logic [9:0] a_in_data, a_out_data;
   logic [4:0] a_count;

   logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic       b_almost_full, b_almost_empty;
   logic [9:0] b_in_data, b_out_data;
   logic [2:0] b_count;

   int total;
   int bad;

   elastic_fifo #(.WIDTH(10), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(1)) dut16 (
      .clk          (clk),
      .reset        (reset),
      .flush        (a_flush),
      .in_valid     (a_in_valid),
      .in_ready     (a_in_ready),
      .in_data      (a_in_data),
      .out_valid    (a_out_valid),
      .out_ready    (a_out_ready),
      .out_data     (a_out_data),
      .count        (a_count),
      .almost_full  (a_almost_full),
      .almost_empty (a_almost_empty)
   );

   elastic_fifo #(.WIDTH(10), .DEPTH(5), .AF_LEVEL(4), .AE_LEVEL(0)) dut5 (
      .clk          (clk),
      .reset        (reset),
      .flush        (b_flush),
      .in_valid     (b_in_valid),
      .in_ready     (b_in_ready),
      .in_data      (b_in_data),
      .out_valid    (b_out_valid),
      .out_ready    (b_out_ready),
      .out_data     (b_out_data),
      .count        (b_count),
      .almost_full  (b_almost_full),
      .almost_empty (b_almost_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_a_idle(input string tag);
      check({tag, ".count"},     32'(a_count),        32'd0);
      check({tag, ".out_valid"}, 32'(a_out_valid),    32'd0);
      check({tag, ".in_ready"},  32'(a_in_ready),     32'd1);
      check({tag, ".ae"},        32'(a_almost_empty), 32'd1);
      check({tag, ".af"},        32'(a_almost_full),  32'd0);
      check({tag, ".out_data"},  32'(a_out_data),     32'h000);
   endtask

   logic [9:0] q[$];
   logic       m_push;
   logic       m_pop;

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      {a_flush, a_in_valid, a_out_ready} = '0;
      {b_flush, b_in_valid, b_out_ready} = '0;
      a_in_data = '0;
      b_in_data = '0;

      #3;
      check_a_idle("rst");
      check("rst5.in_ready", 32'(b_in_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;
      step();

      // Single word: visible the cycle after the push, gone the cycle after the pop.
      a_in_valid = 1'b1;
      a_in_data  = 10'h007;
      step();
      a_in_valid = 1'b0;
      check("single.out_valid", 32'(a_out_valid), 32'd1);
      check("single.out_data",  32'(a_out_data),  32'h007);
      check("single.count",     32'(a_count),     32'd1);
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;
      check("single.pop_count", 32'(a_count),     32'd0);
      check("single.pop_valid", 32'(a_out_valid), 32'd0);

      // Fill to full with the consumer stalled.
      for (int i = 0; i < 16; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 10'(i);
         step();
         check("fill.count",    32'(a_count),       32'(i + 1));
         check("fill.af",       32'(a_almost_full), 32'((i + 1) >= 14));
         check("fill.in_ready", 32'(a_in_ready),    32'((i + 1) < 16));
      end
      a_in_data = 10'h3FF;
      step();
      a_in_valid = 1'b0;
      check("full.count",    32'(a_count),    32'd16);
      check("full.in_ready", 32'(a_in_ready), 32'd0);

      for (int i = 0; i < 16; i++) begin
         check("drain.out_data", 32'(a_out_data), 32'(i));
         a_out_ready = 1'b1;
         step();
         if (i == 0) check("drain.in_ready", 32'(a_in_ready), 32'd1);
      end
      a_out_ready = 1'b0;
      check("drain.count",     32'(a_count),     32'd0);
      check("drain.out_valid", 32'(a_out_valid), 32'd0);

      // Preload 8 words, then stream 40 concurrent push/pop cycles across the wrap.
      for (int i = 0; i < 8; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 10'(i);
         step();
      end
      check("wrap.preload", 32'(a_count), 32'd8);
      a_out_ready = 1'b1;
      for (int k = 0; k < 40; k++) begin
         a_in_data = 10'(8 + k);
         check("wrap.out_data", 32'(a_out_data), 32'(k));
         step();
         check("wrap.count", 32'(a_count), 32'd8);
      end
      a_in_valid = 1'b0;
      for (int j = 0; j < 8; j++) begin
         check("wrap.tail", 32'(a_out_data), 32'(40 + j));
         step();
      end
      a_out_ready = 1'b0;
      check("wrap.empty", 32'(a_count), 32'd0);

      // Flush with a producer waiting and a pop in flight.
      for (int i = 0; i < 9; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 10'(10'h100 + i);
         step();
      end
      check("flush.pre_count", 32'(a_count), 32'd9);
      a_flush     = 1'b1;
      a_in_data   = 10'h155;
      a_out_ready = 1'b1;
      #1;
      check("flush.in_ready", 32'(a_in_ready), 32'd0);
      step();
      a_flush     = 1'b0;
      a_in_valid  = 1'b0;
      a_out_ready = 1'b0;
      check("flush.count",     32'(a_count),     32'd0);
      check("flush.out_valid", 32'(a_out_valid), 32'd0);
      a_in_valid = 1'b1;
      a_in_data  = 10'h0AB;
      step();
      a_in_valid = 1'b0;
      check("flush.first", 32'(a_out_data), 32'h0AB);
      check("flush.one",   32'(a_count),    32'd1);
      a_out_ready = 1'b1;
      step();
      a_out_ready = 1'b0;

      // Asynchronous reset mid-stream, checked before any further clock edge.
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1'b1;
         a_in_data  = 10'(10'h0C0 + i);
         step();
      end
      a_in_valid = 1'b0;
      check("midrst.pre", 32'(a_count), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      check_a_idle("midrst");
      #1;
      reset = 1'b0;
      step();

      // DEPTH=5: fill, overflow attempt, drain.
      for (int i = 0; i < 5; i++) begin
         b_in_valid = 1'b1;
         b_in_data  = 10'(10'h020 + i);
         step();
         check("f5.count", 32'(b_count),       32'(i + 1));
         check("f5.af",    32'(b_almost_full), 32'((i + 1) >= 4));
         check("f5.ae",    32'(b_almost_empty), 32'd0);
      end
      b_in_data = 10'h3FF;
      step();
      b_in_valid = 1'b0;
      check("f5.full",     32'(b_count),    32'd5);
      check("f5.in_ready", 32'(b_in_ready), 32'd0);
      for (int i = 0; i < 5; i++) begin
         check("f5.drain", 32'(b_out_data), 32'(10'h020 + i));
         b_out_ready = 1'b1;
         step();
      end
      b_out_ready = 1'b0;
      check("f5.empty", 32'(b_count),        32'd0);
      check("f5.ae0",   32'(b_almost_empty), 32'd1);

      // DEPTH=5: random push/pop against a queue model.
      for (int c = 0; c < 100; c++) begin
         b_in_valid  = 1'($urandom_range(0, 1));
         b_out_ready = 1'($urandom_range(0, 1));
         b_in_data   = 10'($urandom_range(0, 1023));
         check("r5.out_valid", 32'(b_out_valid), 32'(q.size() != 0));
         check("r5.in_ready",  32'(b_in_ready),  32'(q.size() != 5));
         if (q.size() != 0) check("r5.out_data", 32'(b_out_data), 32'(q[0]));
         m_push = b_in_valid && (q.size() < 5);
         m_pop  = b_out_ready && (q.size() > 0);
         if (m_pop)  void'(q.pop_front());
         if (m_push) q.push_back(b_in_data);
         step();
         check("r5.count", 32'(b_count), 32'(q.size()));
      end
      b_in_valid  = 1'b0;
      b_out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (q.size() != 0) begin
            check("r5.tail", 32'(b_out_data), 32'(q[0]));
            void'(q.pop_front());
            step();
         end
      end
      b_out_ready = 1'b0;
      check("r5.final", 32'(b_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
